// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// It latches the winning operation, drives the ALU for one cycle and returns the result over a valid/ready channel.
module alu_share_arbiter #(
   parameter int DW = 32,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [CW-1:0] req0_code,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [CW-1:0] req1_code,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic [DW-1:0] rsp0_result,
   output logic          rsp0_err,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [DW-1:0] rsp1_result,
   output logic          rsp1_err,
   output logic [CW-1:0] alu_code,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_result
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state_q, state_d;
   logic          last_q;
   logic          owner_q;
   logic          illegal_q;
   logic          err_q;
   logic [CW-1:0] code_q;
   logic [DW-1:0] a_q, b_q, result_q;

   logic          grant_sel;
   logic          accept;
   logic [CW-1:0] sel_code;
   logic [DW-1:0] sel_a, sel_b;

   // Codes the result mux decodes: 0x00-0x08 and 0x10-0x14.
   function automatic logic is_legal(input logic [CW-1:0] code);
      return (code <= CW'(8)) || ((code >= CW'(16)) && (code <= CW'(20)));
   endfunction

   // On a tie the requester not served last wins.
   always_comb begin
      grant_sel = 1'b0;
      if (req0_valid && req1_valid)
         grant_sel = ~last_q;
      else
         grant_sel = req1_valid;
      accept   = (state_q == IDLE) && rst_n && (req0_valid || req1_valid);
      sel_code = grant_sel ? req1_code : req0_code;
      sel_a    = grant_sel ? req1_a : req0_a;
      sel_b    = grant_sel ? req1_b : req0_b;
   end

   assign req0_ready = accept && !grant_sel;
   assign req1_ready = accept && grant_sel;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         illegal_q <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            code_q    <= sel_code;
            a_q       <= sel_a;
            b_q       <= sel_b;
            owner_q   <= grant_sel;
            last_q    <= grant_sel;
            illegal_q <= !is_legal(sel_code);
         end
         // An illegal code never lets the undecoded mux output escape.
         if (state_q == EXEC) begin
            result_q <= illegal_q ? '0 : alu_result;
            err_q    <= illegal_q;
         end
      end
   end

   assign alu_code    = code_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign rsp0_valid  = (state_q == RESP) && !owner_q;
   assign rsp1_valid  = (state_q == RESP) && owner_q;
   assign rsp0_err    = err_q && rsp0_valid;
   assign rsp1_err    = err_q && rsp1_valid;
   assign rsp0_result = result_q;
   assign rsp1_result = result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a small ALU model feeds alu_result,
// a vector table covers single operations and hand-written sequences cover arbitration, backpressure and reset.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_code, req1_code, alu_code;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp0_err;
   logic        rsp1_valid, rsp1_ready, rsp1_err;
   logic [31:0] rsp0_result, rsp1_result;
   logic [31:0] alu_a, alu_b, alu_result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DW(32), .CW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_code(req0_code),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_code(req1_code),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
      .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
   );

   // Stand-in for the shared ALU; undecoded codes produce garbage on purpose.
   always_comb begin
      alu_result = 32'hDEADBEEF;
      case (alu_code)
         5'h00: alu_result = alu_a + alu_b;
         5'h01, 5'h06: alu_result = alu_a & alu_b;
         5'h02, 5'h07: alu_result = alu_a ^ alu_b;
         5'h03, 5'h08: alu_result = alu_a | alu_b;
         5'h04: alu_result = ~(alu_a | alu_b);
         5'h05: alu_result = alu_a - alu_b;
         5'h10: alu_result = alu_a << alu_b[4:0];
         5'h11: alu_result = alu_a >> alu_b[4:0];
         5'h12: alu_result = $signed(alu_a) >>> alu_b[4:0];
         5'h13: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         5'h14: alu_result = {31'd0, alu_a < alu_b};
         default: alu_result = 32'hDEADBEEF;
      endcase
   end

   typedef struct {
      logic        port;
      logic [4:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
   } vec_t;

   vec_t vecs[16];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   // Runs one operation on one port; entered and left just after a rising edge in IDLE.
   task automatic apply_stimulus(input logic port, input logic [4:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      if (port) begin
         req1_valid = 1'b1; req1_code = code; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_code = code; req0_a = a; req0_b = b;
      end
      #1;
      check_output("op_ready", {31'd0, port ? req1_ready : req0_ready}, 32'd1);
      check_output("op_other_ready", {31'd0, port ? req0_ready : req1_ready}, 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check_output("op_alu_code", {27'd0, alu_code}, {27'd0, code});
      check_output("op_alu_a", alu_a, a);
      check_output("op_alu_b", alu_b, b);
      check_output("op_early_valid", {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd0);
      @(posedge clk); #1;
      check_output("op_rsp_valid", {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd1);
      check_output("op_other_valid", {31'd0, port ? rsp0_valid : rsp1_valid}, 32'd0);
      check_output("op_result", port ? rsp1_result : rsp0_result, exp_res);
      check_output("op_err", {31'd0, port ? rsp1_err : rsp0_err}, {31'd0, exp_err});
      @(posedge clk); #1;
      check_output("op_done", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 5'h00, 32'd5,         32'd7,         32'd12,        1'b0};
      vecs[1]  = '{1'b0, 5'h05, 32'd3,         32'd5,         32'hFFFFFFFE,  1'b0};
      vecs[2]  = '{1'b1, 5'h02, 32'hFF00FF00,  32'h0FF00FF0,  32'hF0F0F0F0,  1'b0};
      vecs[3]  = '{1'b1, 5'h04, 32'd0,         32'd0,         32'hFFFFFFFF,  1'b0};
      vecs[4]  = '{1'b0, 5'h10, 32'd1,         32'd31,        32'h80000000,  1'b0};
      vecs[5]  = '{1'b0, 5'h11, 32'h80000000,  32'd4,         32'h08000000,  1'b0};
      vecs[6]  = '{1'b1, 5'h13, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0};
      vecs[7]  = '{1'b1, 5'h14, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
      vecs[8]  = '{1'b0, 5'h09, 32'd1,         32'd2,         32'd0,         1'b1};
      vecs[9]  = '{1'b1, 5'h15, 32'd1,         32'd2,         32'd0,         1'b1};
      vecs[10] = '{1'b1, 5'h0A, 32'd9,         32'd9,         32'd0,         1'b1};
      vecs[11] = '{1'b1, 5'h08, 32'h10,        32'h01,        32'h11,        1'b0};
      vecs[12] = '{1'b0, 5'h1F, 32'd3,         32'd3,         32'd0,         1'b1};
      vecs[13] = '{1'b0, 5'h01, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0};
      vecs[14] = '{1'b1, 5'h0F, 32'd4,         32'd4,         32'd0,         1'b1};
      vecs[15] = '{1'b0, 5'h10, 32'h3,         32'd2,         32'hC,         1'b0};

      rst_n = 1'b0;
      req0_valid = 1'b1; req0_code = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_code = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #12;
      check_output("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      check_output("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      check_output("rst_alu_code", {27'd0, alu_code}, 32'd0);
      check_output("rst_alu_a", alu_a, 32'd0);
      check_output("rst_result", rsp0_result, 32'd0);
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Continuous contention right after reset: req0 wins the first tie, then alternate.
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_code = 5'h12; req0_a = 32'h80000000; req0_b = 32'd4;
      req1_valid = 1'b1; req1_code = 5'h03; req1_a = 32'hF0;       req1_b = 32'h0F;
      for (int k = 0; k < 4; k++) begin
         logic o;
         o = (k % 2) == 1;
         #1;
         check_output("tie_ready0", {31'd0, req0_ready}, {31'd0, !o});
         check_output("tie_ready1", {31'd0, req1_ready}, {31'd0, o});
         @(posedge clk); #1;
         check_output("tie_alu_code", {27'd0, alu_code}, o ? 32'h03 : 32'h12);
         if (k == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         @(posedge clk); #1;
         check_output("tie_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, !o});
         check_output("tie_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, o});
         check_output("tie_result", o ? rsp1_result : rsp0_result, o ? 32'hFF : 32'hF8000000);
         @(posedge clk);
      end
      #1;

      for (int i = 0; i < 16; i++)
         apply_stimulus(vecs[i].port, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);

      // Backpressure on port 0 while port 1 keeps asking.
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_code = 5'h00; req0_a = 32'd1; req0_b = 32'd2;
      #1;
      check_output("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_code = 5'h01; req1_a = 32'hFF; req1_b = 32'h0F;
      check_output("bp_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check_output("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
         check_output("bp_result", rsp0_result, 32'd3);
         check_output("bp_err", {31'd0, rsp0_err}, 32'd0);
         check_output("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
         @(posedge clk); #1;
      end
      check_output("bp_hold_valid", {31'd0, rsp0_valid}, 32'd1);
      rsp0_ready = 1'b1;
      @(posedge clk); #1;
      check_output("bp_released", {31'd0, rsp0_valid}, 32'd0);
      check_output("bp_req1_accept", {31'd0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      check_output("bp_req1_alu_code", {27'd0, alu_code}, 32'h01);
      @(posedge clk); #1;
      check_output("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check_output("bp_rsp1_result", rsp1_result, 32'h0F);
      @(posedge clk); #1;

      // Reset during EXEC aborts the operation immediately.
      req0_valid = 1'b1; req0_code = 5'h00; req0_a = 32'd100; req0_b = 32'd200;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      check_output("mid_exec_alu_a", alu_a, 32'd100);
      rst_n = 1'b0;
      #1;
      check_output("mid_alu_a", alu_a, 32'd0);
      check_output("mid_alu_b", alu_b, 32'd0);
      check_output("mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      check_output("mid_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_output("mid_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      apply_stimulus(1'b0, 5'h14, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
